// File: rtl/mem_arbiter_if.sv
// One picorv32-style memory port: request side (valid/instr/addr/wdata/wstrb) plus response (ready/rdata).
// The master modport issues requests; the slave modport answers them.
interface mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two masters on one memory port. s_valid rises one cycle after a request; grant held until s_ready,
// master drop-out or watchdog expiry; one idle cycle between transfers. A stalled slave is cut off after TIMEOUT busy cycles.
module mem_arbiter #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_if.slave       m0,
    mem_arbiter_if.slave       m1,
    mem_arbiter_if.master      s,
    output logic               timeout_err
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic            gnt;
    logic            g_valid;
    logic            g_instr;
    logic [31:0]     g_addr;
    logic [31:0]     g_wdata;
    logic [3:0]      g_wstrb;
    logic            wd_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
        end
    end

    // Request mux toward the memory follows whichever master owns the port.
    assign gnt     = (state_q == BUSY1);
    assign g_valid = gnt ? m1.valid : m0.valid;
    assign g_instr = gnt ? m1.instr : m0.instr;
    assign g_addr  = gnt ? m1.addr  : m0.addr;
    assign g_wdata = gnt ? m1.wdata : m0.wdata;
    assign g_wstrb = gnt ? m1.wstrb : m0.wstrb;

    assign wd_expire = (TIMEOUT != 0) && (state_q != IDLE) && (wd_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_d         = '0;
        s.valid      = 1'b0;
        s.instr      = 1'b0;
        s.addr       = '0;
        s.wdata      = '0;
        s.wstrb      = '0;
        m0.ready     = 1'b0;
        m1.ready     = 1'b0;
        m0.rdata     = s.rdata;
        m1.rdata     = s.rdata;
        timeout_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0.valid && m1.valid) begin
                    state_d = last_grant_q ? BUSY0 : BUSY1;
                end else if (m0.valid) begin
                    state_d = BUSY0;
                end else if (m1.valid) begin
                    state_d = BUSY1;
                end
            end

            BUSY0, BUSY1: begin
                s.instr = g_instr;
                s.addr  = g_addr;
                s.wdata = g_wdata;
                s.wstrb = g_wstrb;
                s.valid = g_valid && !(wd_expire && !s.ready);

                if (!g_valid) begin
                    // Master abandoned its request: release without a response.
                    state_d = IDLE;
                end else if (s.ready || wd_expire) begin
                    state_d      = IDLE;
                    last_grant_d = gnt;
                    if (gnt) begin
                        m1.ready = 1'b1;
                    end else begin
                        m0.ready = 1'b1;
                    end
                    if (!s.ready) begin
                        timeout_err = 1'b1;
                        if (gnt) begin
                            m1.rdata = ERR_DATA;
                        end else begin
                            m0.rdata = ERR_DATA;
                        end
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, every cycle compared against a transfer-level model.
module tb_mem_arbiter;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    logic timeout_err;

    always #5 clk = ~clk;

    mem_arbiter_if m0_bus ();
    mem_arbiter_if m1_bus ();
    mem_arbiter_if s_bus ();

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .timeout_err (timeout_err)
    );

    // Stimulus state for both masters and the memory
    logic        mv [2];
    logic        mi [2];
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        rst_r;
    logic        s_rdy;
    logic [31:0] s_rd;

    // Reference model: who owns the port, how long it has owned it, who was served last
    int owner;
    int last_served;
    int n_busy;
    int mem_lat;
    int fixed_lat;
    bit idle_noise;
    bit use_rd;
    logic [31:0] fixed_rd;
    bit got [2];
    int served [2];
    int n_to;

    int n_chk;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return r % 4;
        if (r == 6) return TO - 1;
        if (r <= 8) return 99;
        return 0;
    endfunction

    task automatic step();
        logic        ev, ei, er0, er1, eto, x_mv;
        logic [31:0] ea, ewd, erd0, erd1;
        logic [3:0]  ews;
        @(negedge clk);
        s_rdy = 1'b0;
        s_rd  = use_rd ? fixed_rd : $urandom;
        if (owner >= 0 && mv[owner] && n_busy == mem_lat + 1) s_rdy = 1'b1;
        else if (owner < 0 && idle_noise) s_rdy = 1'($urandom_range(0, 1));
        m0_bus.valid = mv[0]; m0_bus.instr = mi[0]; m0_bus.addr = ma[0];
        m0_bus.wdata = mw[0]; m0_bus.wstrb = ms[0];
        m1_bus.valid = mv[1]; m1_bus.instr = mi[1]; m1_bus.addr = ma[1];
        m1_bus.wdata = mw[1]; m1_bus.wstrb = ms[1];
        s_bus.ready = s_rdy;
        s_bus.rdata = s_rd;
        rst = rst_r;
        #1;
        ev = 0; ei = 0; ea = '0; ewd = '0; ews = '0; er0 = 0; er1 = 0; eto = 0;
        erd0 = s_rd; erd1 = s_rd;
        if (owner >= 0) begin
            x_mv = mv[owner];
            eto  = (n_busy == TO) && !s_rdy && x_mv;
            ev   = x_mv && !eto;
            ei   = mi[owner]; ea = ma[owner]; ewd = mw[owner]; ews = ms[owner];
            if (owner == 0) begin
                er0 = x_mv && (s_rdy || eto);
                if (eto) erd0 = ERR;
            end else begin
                er1 = x_mv && (s_rdy || eto);
                if (eto) erd1 = ERR;
            end
        end
        check("s_valid", s_bus.valid, ev);
        check("s_instr", s_bus.instr, ei);
        check("s_addr", s_bus.addr, ea);
        check("s_wdata", s_bus.wdata, ewd);
        check("s_wstrb", s_bus.wstrb, ews);
        check("m0_ready", m0_bus.ready, er0);
        check("m1_ready", m1_bus.ready, er1);
        check("m0_rdata", m0_bus.rdata, erd0);
        check("m1_rdata", m1_bus.rdata, erd1);
        check("timeout_err", timeout_err, eto);
        got[0] = er0;
        got[1] = er1;
        if (er0) served[0]++;
        if (er1) served[1]++;
        if (eto) n_to++;
        if (rst_r) begin
            owner = -1; last_served = 1; n_busy = 0;
        end else if (owner < 0) begin
            if (mv[0] && mv[1]) owner = (last_served == 0) ? 1 : 0;
            else if (mv[0]) owner = 0;
            else if (mv[1]) owner = 1;
            n_busy  = 1;
            mem_lat = (fixed_lat >= 0) ? fixed_lat : pick_lat();
        end else if (!mv[owner]) begin
            owner = -1;
        end else if (er0 || er1) begin
            last_served = owner; owner = -1;
        end else begin
            n_busy++;
        end
        @(posedge clk);
    endtask

    task automatic new_req(input int i);
        mv[i] = 1'b1;
        mi[i] = 1'($urandom_range(0, 1));
        ma[i] = $urandom;
        mw[i] = $urandom;
        ms[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_ready(input int who, input string tag, output int cycles);
        bit done;
        done = 0;
        cycles = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            cycles++;
            done = got[who];
        end
        check(tag, done, 1);
        mv[who] = 1'b0;
    endtask

    task automatic gen();
        for (int i = 0; i < 2; i++) begin
            if (got[i]) begin
                if ($urandom_range(0, 1) == 1) new_req(i);
                else mv[i] = 1'b0;
            end else if (!mv[i]) begin
                if ($urandom_range(0, 3) == 0) new_req(i);
            end else if (owner == i && $urandom_range(0, 40) == 0) begin
                mv[i] = 1'b0;
            end
        end
        rst_r = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int cyc, snap, winner;
        bit any;
        n_chk = 0; n_fail = 0; n_to = 0;
        served[0] = 0; served[1] = 0;
        got[0] = 0; got[1] = 0;
        fixed_lat = 1; idle_noise = 0; use_rd = 0; fixed_rd = '0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mi[i] = 0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
        end
        m0_bus.valid = 0; m0_bus.instr = 0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.valid = 0; m1_bus.instr = 0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        s_bus.ready = 0; s_bus.rdata = '0;
        rst = 1'b1;
        rst_r = 1'b0;
        repeat (2) @(posedge clk);
        owner = -1; last_served = 1; n_busy = 0; mem_lat = 0;

        // Reset state, with the memory asserting ready while nothing is granted
        idle_noise = 1;
        repeat (3) step();
        idle_noise = 0;

        // Simultaneous requests: m0 first out of reset, then strict alternation
        new_req(0); new_req(1);
        for (int k = 0; k < 8; k++) begin
            any = 0;
            for (int t = 0; t < 40 && !any; t++) begin
                step();
                any = got[0] || got[1];
            end
            winner = got[1] ? 1 : 0;
            check("alternate", winner, k % 2);
            if (k < 7) new_req(winner);
        end
        mv[0] = 0; mv[1] = 0;
        step();

        // Single m0 read, memory answers two cycles after s_valid
        fixed_lat = 2; use_rd = 1; fixed_rd = 32'h12345678;
        new_req(0); ma[0] = 32'h100; mw[0] = '0; ms[0] = 4'b0000; mi[0] = 0;
        wait_ready(0, "m0_read_done", cyc);
        check("m0_read_latency", cyc, 4);
        use_rd = 0;
        step();

        // m1 partial write
        fixed_lat = 1;
        new_req(1); ma[1] = 32'h20; mw[1] = 32'hA5A5A5A5; ms[1] = 4'b0011;
        wait_ready(1, "m1_write_done", cyc);
        step();

        // Watchdog expiry on a silent memory
        fixed_lat = 99;
        snap = n_to;
        new_req(0);
        wait_ready(0, "timeout_done", cyc);
        check("timeout_latency", cyc, TO + 1);
        check("timeout_count", n_to - snap, 1);
        step();

        // Memory answers on the watchdog's last cycle: normal completion
        fixed_lat = TO - 1;
        snap = n_to;
        new_req(0);
        wait_ready(0, "late_ready_done", cyc);
        check("late_ready_no_err", n_to - snap, 0);
        step();

        // Reset while m1 owns the port, m0 requesting: m0 wins afterwards
        fixed_lat = 99;
        new_req(1);
        repeat (4) step();
        new_req(0);
        rst_r = 1;
        step();
        rst_r = 0;
        fixed_lat = 1;
        wait_ready(0, "post_rst_m0", cyc);
        wait_ready(1, "post_rst_m1", cyc);
        step();

        // m0 abandons its request; pending m1 goes next, m0 never acknowledged
        fixed_lat = 99;
        new_req(0);
        repeat (3) step();
        new_req(1);
        step();
        mv[0] = 0;
        snap = served[0];
        fixed_lat = 1;
        step();
        wait_ready(1, "abort_then_m1", cyc);
        check("abort_no_ready", served[0] - snap, 0);
        step();

        // Random traffic
        fixed_lat = -1; idle_noise = 1;
        snap = served[0] + served[1];
        for (int c = 0; c < 4000; c++) begin
            gen();
            step();
        end
        rst_r = 0;
        check("random_progress", (served[0] + served[1] - snap) > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
